// File: rtl/bus_arbiter_if.sv
// Signal bundle for bus_arbiter: four requester ports and the shared bus.
// master = requester side, slave = arbiter side.
interface bus_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 256
);
  logic [3:0]        Req;
  logic [3:0]        Done;
  logic [ADDR_W-1:0] Addr0, Addr1, Addr2, Addr3;
  logic              nRead0, nRead1, nRead2, nRead3;
  logic              nWrite0, nWrite1, nWrite2, nWrite3;
  logic [DATA_W-1:0] Data0, Data1, Data2, Data3;

  logic [3:0]        Grant;
  logic [1:0]        GrantId;
  logic [ADDR_W-1:0] address;
  logic              nRead;
  logic              nWrite;
  logic [DATA_W-1:0] BusDataOut;
  logic              BusBusy;
  logic              TimeoutErr;

  modport master (
    output Req, Done,
    output Addr0, Addr1, Addr2, Addr3,
    output nRead0, nRead1, nRead2, nRead3,
    output nWrite0, nWrite1, nWrite2, nWrite3,
    output Data0, Data1, Data2, Data3,
    input  Grant, GrantId, address, nRead, nWrite, BusDataOut, BusBusy, TimeoutErr
  );

  modport slave (
    input  Req, Done,
    input  Addr0, Addr1, Addr2, Addr3,
    input  nRead0, nRead1, nRead2, nRead3,
    input  nWrite0, nWrite1, nWrite2, nWrite3,
    input  Data0, Data1, Data2, Data3,
    output Grant, GrantId, address, nRead, nWrite, BusDataOut, BusBusy, TimeoutErr
  );
endinterface

// File: rtl/bus_arbiter.sv
// Four-requester round-robin arbiter for a shared bus, state updates on falling Clk edge.
// Define BUS_ARB_TIMEOUT_EN to build the hold counter, forced release and TimeoutErr.
module bus_arbiter #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 256,
  parameter int unsigned MAX_HOLD = 16
) (
  input logic             Clk,
  input logic             nReset,
  bus_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {StIdle, StGrant, StOwn, StRelease} state_e;

  state_e     state_q, state_d;
  logic [1:0] grant_id_q, grant_id_d;
  logic [1:0] last_id_q, last_id_d;

  logic              pick_valid;
  logic [1:0]        pick_id;
  logic              own_req, own_done, own_nrd, own_nwr;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_data;
  logic              timeout;

  // Owner's request-side signals; non-owners never reach the bus.
  always_comb begin
    own_req  = bus.Req[grant_id_q];
    own_done = bus.Done[grant_id_q];
    own_addr = '0;
    own_data = '0;
    own_nrd  = 1'b1;
    own_nwr  = 1'b1;
    unique case (grant_id_q)
      2'd0: begin
        own_addr = bus.Addr0; own_data = bus.Data0; own_nrd = bus.nRead0; own_nwr = bus.nWrite0;
      end
      2'd1: begin
        own_addr = bus.Addr1; own_data = bus.Data1; own_nrd = bus.nRead1; own_nwr = bus.nWrite1;
      end
      2'd2: begin
        own_addr = bus.Addr2; own_data = bus.Data2; own_nrd = bus.nRead2; own_nwr = bus.nWrite2;
      end
      2'd3: begin
        own_addr = bus.Addr3; own_data = bus.Data3; own_nrd = bus.nRead3; own_nwr = bus.nWrite3;
      end
      default: ;
    endcase
  end

  // Scan from last_id+1 upward with wrap; descending loop lets the nearest set bit win.
  always_comb begin
    logic [1:0] cand;
    pick_valid = |bus.Req;
    pick_id    = last_id_q;
    for (int k = 4; k >= 1; k--) begin
      cand = last_id_q + k[1:0];
      if (bus.Req[cand]) pick_id = cand;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    last_id_d  = last_id_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_id_d = pick_id;
          state_d    = StGrant;
        end
      end
      StGrant: state_d = StOwn;
      StOwn: begin
        if (own_done || !own_req || timeout) state_d = StRelease;
      end
      StRelease: begin
        last_id_d = grant_id_q;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(negedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q    <= StIdle;
      grant_id_q <= 2'd0;
      last_id_q  <= 2'd3;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      last_id_q  <= last_id_d;
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int unsigned HoldW = $clog2(MAX_HOLD) + 1;

  logic [HoldW-1:0] hold_q, hold_d;
  logic             timeout_err_q, timeout_err_d;

  assign timeout = (state_q == StOwn) && (hold_q == HoldW'(MAX_HOLD - 1));

  always_comb begin
    hold_d = hold_q;
    if (state_q == StGrant) begin
      hold_d = '0;
    end else if (state_q == StOwn) begin
      hold_d = (&hold_q) ? hold_q : hold_q + 1'b1;
    end
    // Done or a Req drop in the same cycle makes it an ordinary release.
    timeout_err_d = timeout && !own_done && own_req;
  end

  always_ff @(negedge Clk or negedge nReset) begin
    if (!nReset) begin
      hold_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      hold_q        <= hold_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.TimeoutErr = timeout_err_q;
`else
  assign timeout        = 1'b0;
  assign bus.TimeoutErr = 1'b0;

  // MAX_HOLD has no effect without the timeout logic.
  if (MAX_HOLD == 0) begin : g_no_hold_limit
  end
`endif

  assign bus.GrantId = grant_id_q;

  always_comb begin
    bus.Grant      = '0;
    bus.address    = '0;
    bus.nRead      = 1'b1;
    bus.nWrite     = 1'b1;
    bus.BusDataOut = '0;
    bus.BusBusy    = 1'b0;
    unique case (state_q)
      StGrant: begin
        bus.Grant      = 4'b0001 << grant_id_q;
        bus.address    = own_addr;
        bus.BusDataOut = own_data;
        bus.BusBusy    = 1'b1;
      end
      StOwn: begin
        bus.Grant      = 4'b0001 << grant_id_q;
        bus.address    = own_addr;
        bus.BusDataOut = own_data;
        bus.nRead      = own_nrd;
        bus.nWrite     = own_nwr;
        bus.BusBusy    = 1'b1;
      end
      StRelease: bus.BusBusy = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed table, corner sequences, random vs reference model.
module tb_bus_arbiter;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 256;
  localparam int unsigned MAX_HOLD = 16;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic Clk = 1'b1;
  logic nReset = 1'b0;
  always #5 Clk = ~Clk;

  bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .Clk   (Clk),
    .nReset(nReset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0]    req, done, t_nrd, t_nwr;
  logic [AW-1:0] t_addr [4];
  logic [DW-1:0] t_data [4];

  // Reference model: who owns the bus and which phase of the transaction it is in.
  int m_owner, m_held, m_last, m_gid;
  bit m_setup, m_rel, m_terr;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic apply();
    bus.Req = req; bus.Done = done;
    bus.Addr0 = t_addr[0]; bus.Addr1 = t_addr[1]; bus.Addr2 = t_addr[2]; bus.Addr3 = t_addr[3];
    bus.Data0 = t_data[0]; bus.Data1 = t_data[1]; bus.Data2 = t_data[2]; bus.Data3 = t_data[3];
    bus.nRead0 = t_nrd[0]; bus.nRead1 = t_nrd[1]; bus.nRead2 = t_nrd[2]; bus.nRead3 = t_nrd[3];
    bus.nWrite0 = t_nwr[0]; bus.nWrite1 = t_nwr[1];
    bus.nWrite2 = t_nwr[2]; bus.nWrite3 = t_nwr[3];
  endtask

  task automatic model_reset();
    m_owner = -1; m_held = 0; m_last = 3; m_gid = 0;
    m_setup = 0; m_rel = 0; m_terr = 0;
  endtask

  task automatic compare_model();
    logic [3:0] eg; logic [AW-1:0] ea; logic [DW-1:0] ed; logic enr, enw, eb;
    eg = '0; ea = '0; ed = '0; enr = 1'b1; enw = 1'b1;
    eb = (m_owner >= 0) || m_rel;
    if (m_owner >= 0) begin
      eg = 4'(1 << m_owner);
      ea = t_addr[m_owner];
      ed = t_data[m_owner];
      if (!m_setup) begin
        enr = t_nrd[m_owner];
        enw = t_nwr[m_owner];
      end
    end
    chk("grant", bus.Grant, eg);
    chk("grant_id", bus.GrantId, m_gid);
    chk("busy", bus.BusBusy, eb);
    chk("address", bus.address, ea);
    chk("n_read", bus.nRead, enr);
    chk("n_write", bus.nWrite, enw);
    chk("data_out", bus.BusDataOut, ed);
    chk("timeout_err", bus.TimeoutErr, m_terr);
  endtask

  task automatic model_step();
    bit found;
    if (!nReset) return;
    m_terr = 1'b0;
    if (m_rel) begin
      m_rel  = 1'b0;
      m_last = m_gid;
    end else if (m_owner >= 0) begin
      if (m_setup) begin
        m_setup = 1'b0;
        m_held  = 0;
      end else begin
        bit o_done, o_req, expired;
        m_held++;
        o_done  = done[m_owner];
        o_req   = req[m_owner];
        expired = TO_EN && (m_held >= int'(MAX_HOLD));
        if (o_done || !o_req || expired) begin
          m_terr  = expired && !o_done && o_req;
          m_owner = -1;
          m_rel   = 1'b1;
        end
      end
    end else if (req != 4'b0) begin
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        int id;
        id = (m_last + k) % 4;
        if (!found && req[id]) begin
          found = 1'b1; m_owner = id; m_gid = id; m_setup = 1'b1;
        end
      end
    end
  endtask

  task automatic settle_tail();
    compare_model();
    model_step();
    @(negedge Clk);
    #1;
  endtask

  task automatic tick();
    apply();
    @(posedge Clk);
    settle_tail();
  endtask

  task automatic do_reset();
    nReset = 1'b0;
    model_reset();
    #2;
    nReset = 1'b1;
  endtask

  typedef struct {
    logic [3:0]    req;
    logic [3:0]    done;
    logic [3:0]    exp_grant;
    logic [1:0]    exp_gid;
    logic          exp_busy;
    logic [AW-1:0] exp_addr;
    logic          exp_nrd;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    req = '0; done = '0; t_nrd = 4'hF; t_nwr = 4'hF;
    for (int i = 0; i < 4; i++) begin
      t_addr[i] = AW'((i + 1) * 16'h1000);
      t_data[i] = DW'(i + 1) << 200;
    end
    apply();
    model_reset();
    #1;
    compare_model();
    @(negedge Clk);
    #1;
    nReset = 1'b1;

    // Req 0101: 0 first, Done releases, 2 next; then a Req drop ends ownership.
    vecs[0]  = '{4'b0101, 4'b0000, 4'b0000, 2'd0, 1'b0, 16'h0000, 1'b1};
    vecs[1]  = '{4'b0101, 4'b0000, 4'b0001, 2'd0, 1'b1, 16'h1000, 1'b1};
    vecs[2]  = '{4'b0101, 4'b0001, 4'b0001, 2'd0, 1'b1, 16'h1000, 1'b0};
    vecs[3]  = '{4'b0101, 4'b0000, 4'b0000, 2'd0, 1'b1, 16'h0000, 1'b1};
    vecs[4]  = '{4'b0101, 4'b0000, 4'b0000, 2'd0, 1'b0, 16'h0000, 1'b1};
    vecs[5]  = '{4'b0101, 4'b0000, 4'b0100, 2'd2, 1'b1, 16'h3000, 1'b1};
    vecs[6]  = '{4'b0101, 4'b0100, 4'b0100, 2'd2, 1'b1, 16'h3000, 1'b0};
    vecs[7]  = '{4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b1, 16'h0000, 1'b1};
    vecs[8]  = '{4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 16'h0000, 1'b1};
    vecs[9]  = '{4'b0001, 4'b0000, 4'b0000, 2'd2, 1'b0, 16'h0000, 1'b1};
    vecs[10] = '{4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b1, 16'h1000, 1'b1};
    vecs[11] = '{4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b1, 16'h1000, 1'b0};
    vecs[12] = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b1, 16'h0000, 1'b1};
    vecs[13] = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 16'h0000, 1'b1};
    t_nrd = 4'b0000;
    for (int i = 0; i < 14; i++) begin
      req = vecs[i].req; done = vecs[i].done;
      apply();
      @(posedge Clk);
      chk("vec_grant", bus.Grant, vecs[i].exp_grant);
      chk("vec_gid", bus.GrantId, vecs[i].exp_gid);
      chk("vec_busy", bus.BusBusy, vecs[i].exp_busy);
      chk("vec_addr", bus.address, vecs[i].exp_addr);
      chk("vec_nrd", bus.nRead, vecs[i].exp_nrd);
      settle_tail();
    end
    t_nrd = 4'hF;

    // Round robin with all requesting, Done on the third OWN cycle.
    do_reset();
    req = 4'b1111; done = '0;
    for (int g = 0; g < 5; g++) begin
      int wait_n;
      wait_n = 0;
      apply();
      #1;
      while (bus.Grant == 4'b0 && wait_n < 8) begin
        tick();
        wait_n++;
      end
      chk("rr_gap", wait_n, (g == 0) ? 1 : 2);
      chk("rr_id", bus.GrantId, g % 4);
      tick(); tick(); tick();
      done = 4'(1 << (g % 4));
      tick();
      done = '0;
    end
    req = '0;
    tick(); tick();

    // Non-owner strobes stay off the bus.
    do_reset();
    t_addr[1] = 16'h3002; t_addr[2] = 16'h4000;
    t_nwr = 4'b1001; req = 4'b0010;
    tick(); tick();
    req = 4'b0110;
    apply();
    #1;
    chk("own_addr", bus.address, 16'h3002);
    chk("own_nwrite", bus.nWrite, 1'b0);
    chk("own_grant", bus.Grant, 4'b0010);
    t_nwr = 4'b1011;
    apply();
    #1;
    chk("own_nwrite_other", bus.nWrite, 1'b1);
    tick();
    done = 4'b0010;
    tick();
    done = '0; t_nwr = 4'hF;
    tick(); tick(); tick();
    chk("next_owner", bus.GrantId, 2);
    req = '0;
    tick(); tick(); tick();

    // Owner holds without Done.
    do_reset();
    req = 4'b0001;
    tick(); tick();
    begin
      int own_n;
      own_n = 0;
      while (bus.Grant == 4'b0001 && own_n < 40) begin
        tick();
        own_n++;
      end
      chk("hold_len", own_n, TO_EN ? MAX_HOLD : 40);
      chk("timeout_pulse", bus.TimeoutErr, TO_EN);
      tick();
      chk("timeout_clear", bus.TimeoutErr, 1'b0);
    end
    done = 4'b0001;
    tick();
    done = '0; req = '0;
    tick(); tick(); tick();

    // Done on the last allowed OWN cycle wins over the timeout.
    do_reset();
    req = 4'b0001;
    tick(); tick();
    for (int c = 0; c < int'(MAX_HOLD) - 1; c++) tick();
    done = 4'b0001;
    tick();
    done = '0; req = '0;
    chk("done_wins_terr", bus.TimeoutErr, 1'b0);
    chk("done_wins_rel", bus.Grant, 4'b0000);
    tick(); tick();

    // Reset in the middle of requester 2's OWN phase.
    do_reset();
    req = 4'b0100; t_nwr = 4'b1011;
    tick(); tick();
    chk("pre_rst_nwrite", bus.nWrite, 1'b0);
    #1;
    nReset = 1'b0;
    model_reset();
    #1;
    chk("rst_grant", bus.Grant, 4'b0000);
    chk("rst_nwrite", bus.nWrite, 1'b1);
    chk("rst_busy", bus.BusBusy, 1'b0);
    chk("rst_gid", bus.GrantId, 0);
    #1;
    nReset = 1'b1;
    req = 4'b0110; t_nwr = 4'hF;
    tick();
    chk("rst_prio", bus.GrantId, 1);
    req = '0;
    tick(); tick(); tick(); tick();

    // Random traffic, then a phase of sticky requests to reach the hold limit.
    for (int c = 0; c < 3500; c++) begin
      bit sticky;
      sticky = (c >= 2000);
      for (int i = 0; i < 4; i++) begin
        if (sticky) begin
          req[i]  = ($urandom_range(99) >= 3);
          done[i] = ($urandom_range(99) < 3);
        end else begin
          req[i]  = $urandom_range(1);
          done[i] = ($urandom_range(99) < 20);
        end
        t_nrd[i]  = $urandom_range(1);
        t_nwr[i]  = $urandom_range(1);
        t_addr[i] = AW'($urandom());
        for (int w = 0; w < DW / 32; w++) t_data[i][w*32 +: 32] = $urandom();
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning the shared address bus width.
REQ-002 SHALL have parameter DATA_W, default 256, meaning the shared write-data bus width.
REQ-003 SHALL have parameter MAX_HOLD, default 16, meaning the maximum number of OWN cycles before forced release.
REQ-004 SHALL have port Clk, input, 1, the single clock; all state updates occur on the falling edge.
REQ-005 SHALL have port nReset, input, 1, an asynchronous active-low reset.
REQ-006 SHALL have port Req, input, 4, the per-requester bus request, active-high, index = requester id.
REQ-007 SHALL have port Done, input, 4, the per-requester transaction-complete strobe, active-high.
REQ-008 SHALL have ports Addr0..Addr3, input, ADDR_W, the requester addresses.
REQ-009 SHALL have ports nRead0..nRead3 and nWrite0..nWrite3, input, 1 each, the requester strobes, active-low.
REQ-010 SHALL have ports Data0..Data3, input, DATA_W, the requester write data.
REQ-011 SHALL have port Grant, output, 4, a one-hot grant or all-zero.
REQ-012 SHALL have port GrantId, output, 2, the index of the current or last owner.
REQ-013 SHALL have ports address, nRead and nWrite, output, ADDR_W/1/1, the shared bus.
REQ-014 SHALL have port BusDataOut, output, DATA_W, the shared write data.
REQ-015 SHALL have port BusBusy, output, 1, high in the GRANT, OWN and RELEASE states.
REQ-016 SHALL have port TimeoutErr, output, 1, a one-cycle pulse on forced release.

Function
REQ-017 SHALL implement the states IDLE, GRANT, OWN and RELEASE.
REQ-018 IDLE: with any Req bit high, SHALL select the first set bit scanning from (LastId+1) mod 4 upward with wrap, load GrantId, assert Grant, and move to GRANT on the next edge; with Req=0 it SHALL stay in IDLE.
REQ-019 GRANT SHALL last exactly one cycle, with Grant held, nRead=nWrite=1 and address/BusDataOut driven from the owner (setup cycle), then move to OWN.
REQ-020 OWN SHALL drive address, nRead, nWrite and BusDataOut combinationally from the owner's inputs.
REQ-021 OWN SHALL exit to RELEASE when Done[GrantId]=1, when Req[GrantId]=0, or on timeout.
REQ-022 RELEASE SHALL last one cycle with Grant=0, nRead=nWrite=1, address=0 and BusDataOut=0, SHALL set LastId=GrantId, and then move to IDLE.
REQ-023 The grant-to-grant gap SHALL be a minimum of 2 cycles (RELEASE, IDLE); back-to-back ownership by the same requester is allowed only when no other Req bit is set.
REQ-024 In IDLE, the bus SHALL be idle: address=0, nRead=1, nWrite=1, BusDataOut=0, Grant=0.
REQ-025 Non-owner strobes SHALL never reach the bus; Req changes from non-owners during OWN SHALL be ignored until IDLE.
REQ-026 Hold counter: SHALL clear on entry to OWN and increment each OWN cycle; timeout SHALL occur when it reaches MAX_HOLD-1 in OWN.
REQ-027 When Done and timeout occur in the same cycle, Done SHALL win and TimeoutErr SHALL stay 0.
REQ-028 When the owner drops Req and raises Done in the same cycle, it SHALL be treated as a normal release.
REQ-029 The hold counter SHALL be $clog2(MAX_HOLD)+1 bits and SHALL NOT wrap within OWN.

Reset
REQ-030 On nReset=0, the block SHALL asynchronously enter IDLE with Grant=0, GrantId=0, LastId=3, hold counter=0, TimeoutErr=0, BusBusy=0, address=0, nRead=1, nWrite=1 and BusDataOut=0.
REQ-031 On reset during OWN, the bus SHALL release immediately with no TimeoutErr, and after reset deassertion requester 0 SHALL have first priority.

Configuration
REQ-032 The macro BUS_ARB_TIMEOUT_EN SHALL control the timeout feature.
REQ-033 With BUS_ARB_TIMEOUT_EN defined, the hold counter, forced release and TimeoutErr SHALL be present.
REQ-034 With BUS_ARB_TIMEOUT_EN undefined, ownership SHALL end only on Done or Req drop, the counter SHALL NOT be built, and TimeoutErr SHALL be tied to 0; all other behaviour SHALL be identical.

Verification
REQ-035 Reset then Req=4'b0101 -> Grant=0001 (GrantId=0) for GRANT+OWN; Done[0] pulse -> RELEASE, IDLE, then Grant=0100.
REQ-036 Req=4'b1111 held, each owner pulses Done after 3 OWN cycles -> grant order 0,1,2,3,0 with a 2-cycle gap each.
REQ-037 Owner 1 in OWN drives Addr1=16'h3002 and nWrite1=0 while Addr2=16'h4000 and nWrite2=0 -> address=16'h3002 and the bus shows only requester 1 strobes.
REQ-038 With BUS_ARB_TIMEOUT_EN defined and MAX_HOLD=16, owner holds Req without Done -> release after 16 OWN cycles with a TimeoutErr 1-cycle pulse; Done on cycle 16 -> no pulse.
REQ-039 nReset pulsed low mid-OWN of requester 2 -> Grant=0, nWrite=1 immediately; after release, with Req=4'b0110 -> requester 1 granted first.
